// File: rtl/field_bcd_scanner.sv
// Channel-selecting binary-to-BCD converter: snapshots one packed field and
// runs a one-bit-per-cycle double-dabble, in manual (start_i) or auto-scan mode.
module field_bcd_scanner #(
  parameter int N_CH     = 9,
  parameter int W        = 8,
  parameter int N_DIG    = 3,
  parameter int SCAN_GAP = 16,
  localparam int SEL_W   = ($clog2(N_CH) > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_CH*W-1:0]   ch_data_i,
  input  logic [SEL_W-1:0]    sel_i,
  input  logic                mode_i,
  input  logic                start_i,
  output logic                busy_o,
  output logic                valid_o,
  output logic [SEL_W-1:0]    ch_o,
  output logic [4*N_DIG-1:0]  bcd_o,
  output logic                ovf_o,
  output logic                sel_err_o
);

  localparam int BCD_W = 4 * N_DIG;
  localparam int CNT_W = $clog2(W + 1);
  localparam int GAP_W = $clog2(SCAN_GAP + 1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint unsigned LIMIT = pow10(N_DIG);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [W-1:0]       val_q, val_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic               err_pend_q, err_pend_d;
  logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
  logic [SEL_W-1:0]   ch_out_q, ch_out_d;
  logic               ovf_out_q, ovf_out_d;
  logic               err_out_q, err_out_d;

  logic [SEL_W-1:0]   src_sel;
  logic [W-1:0]       src_field;
  logic               src_err;
  logic               start_now;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_step;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d    = state_q;
    sel_d      = sel_q;
    val_d      = val_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    ptr_d      = ptr_q;
    ovf_pend_d = ovf_pend_q;
    err_pend_d = err_pend_q;
    bcd_out_d  = bcd_out_q;
    ch_out_d   = ch_out_q;
    ovf_out_d  = ovf_out_q;
    err_out_d  = err_out_q;
    start_now  = 1'b0;

    // Out-of-range selects leave src_field at 0, which is the value converted.
    src_sel   = mode_i ? ptr_q : sel_i;
    src_err   = int'(src_sel) >= N_CH;
    src_field = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (src_sel == SEL_W'(k)) src_field = ch_data_i[k*W +: W];
    end

    for (int d = 0; d < N_DIG; d++) begin
      bcd_adj[4*d +: 4] = (bcd_q[4*d +: 4] >= 4'd5) ? bcd_q[4*d +: 4] + 4'd3
                                                    : bcd_q[4*d +: 4];
    end
    bcd_step = {bcd_adj[BCD_W-2:0], val_q[W-1]};

    unique case (state_q)
      IDLE: begin
        if (mode_i) begin
          if (gap_q == GAP_W'(SCAN_GAP)) begin
            start_now = 1'b1;
            gap_d     = '0;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end else begin
          gap_d     = '0;
          start_now = start_i;
        end
        if (start_now) begin
          sel_d      = src_sel;
          val_d      = src_field;
          bcd_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = 64'(src_field) >= LIMIT;
          err_pend_d = src_err;
          state_d    = CONV;
        end
      end
      CONV: begin
        val_d = val_q << 1;
        bcd_d = bcd_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(W - 1)) begin
          bcd_out_d = bcd_step;
          ch_out_d  = sel_q;
          ovf_out_d = ovf_pend_q;
          err_out_d = err_pend_q;
          state_d   = DONE;
        end
      end
      DONE: begin
        ptr_d   = (ptr_q == SEL_W'(N_CH - 1)) ? '0 : ptr_q + SEL_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; every flop is reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      val_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      ptr_q      <= '0;
      ovf_pend_q <= 1'b0;
      err_pend_q <= 1'b0;
      bcd_out_q  <= '0;
      ch_out_q   <= '0;
      ovf_out_q  <= 1'b0;
      err_out_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      val_q      <= val_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      ptr_q      <= ptr_d;
      ovf_pend_q <= ovf_pend_d;
      err_pend_q <= err_pend_d;
      bcd_out_q  <= bcd_out_d;
      ch_out_q   <= ch_out_d;
      ovf_out_q  <= ovf_out_d;
      err_out_q  <= err_out_d;
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign valid_o   = (state_q == DONE);
  assign bcd_o     = bcd_out_q;
  assign ch_o      = ch_out_q;
  assign ovf_o     = ovf_out_q;
  assign sel_err_o = err_out_q;

endmodule

// File: tb/tb_field_bcd_scanner.sv
// Directed bench for field_bcd_scanner: a 3-digit and a 2-digit instance share
// all inputs; expected results are hand-computed decimal values.
module tb_field_bcd_scanner;

  localparam int N_CH  = 9;
  localparam int W     = 8;
  localparam int SEL_W = 4;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [N_CH*W-1:0] ch_data_i;
  logic [SEL_W-1:0]  sel_i;
  logic              mode_i;
  logic              start_i;

  logic              busy_o, valid_o, ovf_o, sel_err_o;
  logic [SEL_W-1:0]  ch_o;
  logic [11:0]       bcd_o;
  logic              busy2, valid2, ovf2, err2;
  logic [SEL_W-1:0]  ch2;
  logic [7:0]        bcd2;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  field_bcd_scanner #(.N_CH(N_CH), .W(W), .N_DIG(3), .SCAN_GAP(4)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .ch_data_i(ch_data_i), .sel_i(sel_i),
    .mode_i(mode_i), .start_i(start_i), .busy_o(busy_o), .valid_o(valid_o),
    .ch_o(ch_o), .bcd_o(bcd_o), .ovf_o(ovf_o), .sel_err_o(sel_err_o)
  );

  field_bcd_scanner #(.N_CH(N_CH), .W(W), .N_DIG(2), .SCAN_GAP(4)) u_dut2 (
    .clk_i(clk), .rst_i(rst_i), .ch_data_i(ch_data_i), .sel_i(sel_i),
    .mode_i(mode_i), .start_i(start_i), .busy_o(busy2), .valid_o(valid2),
    .ch_o(ch2), .bcd_o(bcd2), .ovf_o(ovf2), .sel_err_o(err2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start at cycle t, check busy at t+1, valid only at t+W+1, then idle at t+W+2.
  task automatic run_manual(input string tag, input logic [SEL_W-1:0] sel,
                            input bit hold, input int poke_ch, input logic [7:0] poke_val,
                            input logic [11:0] exp_bcd, input logic [SEL_W-1:0] exp_ch,
                            input logic exp_ovf, input logic exp_err);
    sel_i   = sel;
    start_i = 1'b1;
    tick();
    check({tag, " busy@t+1"}, busy_o, 1'b1);
    if (!hold) start_i = 1'b0;
    sel_i = sel + 4'd1;
    if (poke_ch >= 0) ch_data_i[poke_ch*W +: W] = poke_val;
    for (int i = 0; i < W - 1; i++) tick();
    check({tag, " valid@t+W"}, valid_o, 1'b0);
    tick();
    check({tag, " valid@t+W+1"}, valid_o, 1'b1);
    check({tag, " busy@t+W+1"}, busy_o, 1'b1);
    check({tag, " bcd"}, bcd_o, exp_bcd);
    check({tag, " ch"}, ch_o, exp_ch);
    check({tag, " ovf"}, ovf_o, exp_ovf);
    check({tag, " sel_err"}, sel_err_o, exp_err);
    start_i = 1'b0;
    tick();
    check({tag, " busy@t+W+2"}, busy_o, 1'b0);
    check({tag, " hold bcd"}, bcd_o, exp_bcd);
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (valid_o !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check({tag, " valid seen"}, valid_o, 1'b1);
  endtask

  initial begin
    int n;
    int cnt;
    rst_i     = 1'b1;
    ch_data_i = '0;
    sel_i     = '0;
    mode_i    = 1'b0;
    start_i   = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    check("reset busy", busy_o, 1'b0);
    check("reset valid", valid_o, 1'b0);
    check("reset bcd", bcd_o, 12'h000);
    check("reset ch", ch_o, 4'd0);
    check("reset ovf", ovf_o, 1'b0);
    check("reset sel_err", sel_err_o, 1'b0);

    // Basic conversions
    ch_data_i[4*W +: W] = 8'd59;
    ch_data_i[2*W +: W] = 8'd255;
    ch_data_i[0*W +: W] = 8'd0;
    ch_data_i[1*W +: W] = 8'd100;
    run_manual("ch4=59", 4'd4, 0, -1, 8'd0, 12'h059, 4'd4, 1'b0, 1'b0);
    run_manual("ch2=255", 4'd2, 0, -1, 8'd0, 12'h255, 4'd2, 1'b0, 1'b0);
    run_manual("ch0=0", 4'd0, 0, -1, 8'd0, 12'h000, 4'd0, 1'b0, 1'b0);
    run_manual("ch1=100", 4'd1, 0, -1, 8'd0, 12'h100, 4'd1, 1'b0, 1'b0);

    // Overflow on the 2-digit instance
    ch_data_i[5*W +: W] = 8'd199;
    run_manual("ch5=199", 4'd5, 0, -1, 8'd0, 12'h199, 4'd5, 1'b0, 1'b0);
    check("n2 199 bcd", bcd2, 8'h99);
    check("n2 199 ovf", ovf2, 1'b1);
    check("n2 199 ch", ch2, 4'd5);
    ch_data_i[5*W +: W] = 8'd99;
    run_manual("ch5=99", 4'd5, 0, -1, 8'd0, 12'h099, 4'd5, 1'b0, 1'b0);
    check("n2 99 bcd", bcd2, 8'h99);
    check("n2 99 ovf", ovf2, 1'b0);
    check("n2 99 sel_err", err2, 1'b0);
    check("n2 idle", busy2, 1'b0);

    // Bad select with start held through the conversion
    run_manual("sel=12", 4'd12, 1, -1, 8'd0, 12'h000, 4'd12, 1'b0, 1'b1);
    tick();
    check("sel=12 no requeue", busy_o, 1'b0);
    check("sel=12 no extra valid", valid_o, 1'b0);

    // Reset mid-conversion
    run_manual("pre-rst", 4'd4, 0, -1, 8'd0, 12'h059, 4'd4, 1'b0, 1'b0);
    sel_i   = 4'd2;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rst busy", busy_o, 1'b0);
    check("rst valid", valid_o, 1'b0);
    check("rst bcd", bcd_o, 12'h000);
    check("rst ch", ch_o, 4'd0);
    check("rst ovf", ovf_o, 1'b0);
    check("rst sel_err", sel_err_o, 1'b0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (valid_o === 1'b1) cnt++;
      tick();
    end
    check("aborted conv no valid", cnt, 0);
    ch_data_i[3*W +: W] = 8'd37;
    run_manual("snapshot ch3=37", 4'd3, 0, 3, 8'd200, 12'h037, 4'd3, 1'b0, 1'b0);

    // Auto-scan from a fresh pointer: ch k holds k*11, BCD is {k,k}
    rst_i = 1'b1;
    for (int k = 0; k < N_CH; k++) ch_data_i[k*W +: W] = 8'(k * 11);
    tick();
    rst_i  = 1'b0;
    mode_i = 1'b1;
    wait_valid("auto p0", n);
    check("auto p0 ch", ch_o, 4'd0);
    check("auto p0 bcd", bcd_o, 12'h000);
    for (int p = 1; p <= N_CH; p++) begin
      logic [3:0]  k;
      logic [11:0] e;
      k = 4'(p % N_CH);
      e = {4'd0, k, k};
      tick();
      wait_valid($sformatf("auto p%0d", p), n);
      check($sformatf("auto p%0d spacing", p), n + 1, 14);
      check($sformatf("auto p%0d ch", p), ch_o, k);
      check($sformatf("auto p%0d bcd", p), bcd_o, e);
    end
    mode_i = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
